// File: rtl/dff_load_reg_pkg.sv
// Shared constants for the load-enabled register cells.
package dff_load_reg_pkg;

    // Width-independent default reset value; consumers truncate to their width.
    localparam logic [63:0] DEFAULT_RESET_VALUE = 64'h0;

endpackage

// File: rtl/dff_load_bit.sv
// One-bit storage cell: hold/load select, synchronous reset, rising-edge flop.
module dff_load_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic in,
    output logic out
);

    logic q;
    logic d;

    always_comb begin
        d = q;
        if (load) begin
            d = in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

    assign out = q;

endmodule

// File: rtl/dff_load_reg.sv
// WIDTH-bit load-enabled register built from independent one-bit cells.
module dff_load_reg
    import dff_load_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("dff_load_reg: WIDTH must be in 1..64");
    end

    // Every bit shares rst/load; each picks its own reset bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_load_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .in   (in[i]),
            .out  (out[i])
        );
    end

endmodule

// File: tb/tb_dff_load_reg.sv
// Bench for dff_load_reg: 1-bit default instance and 8-bit instance resetting to 8'hA5.
module tb_dff_load_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       in1;
    logic [7:0] in8;
    logic       out1;
    logic [7:0] out8;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       rst;
        logic       load;
        logic       in1;
        logic [7:0] in8;
        logic       exp1;
        logic [7:0] exp8;
    } vec_t;

    typedef struct {
        logic       exp1;
        logic [7:0] exp8;
        string      name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    logic       last1;
    logic [7:0] last8;

    always #20 clk = ~clk;

    dff_load_reg u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .in   (in1),
        .load (load),
        .out  (out1)
    );

    dff_load_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .in   (in8),
        .load (load),
        .out  (out8)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic e1, input logic [7:0] e8, input string name);
        sb_t e;
        e.exp1 = e1;
        e.exp8 = e8;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Wait for the rising edge, then compare both outputs against the oldest expectation.
    task automatic edge_and_check();
        sb_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_out1"}, {7'b0, out1}, {7'b0, e.exp1});
            check({e.name, "_out8"}, out8, e.exp8);
            last1 = e.exp1;
            last8 = e.exp8;
        end
    endtask

    // Drive mid-cycle, confirm no combinational leak, then check after the edge.
    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        rst  = v.rst;
        load = v.load;
        in1  = v.in1;
        in8  = v.in8;
        push_exp(v.exp1, v.exp8, name);
        if (name != "v0") begin
            #1;
            check({name, "_nocomb1"}, {7'b0, out1}, {7'b0, last1});
            check({name, "_nocomb8"}, out8, last8);
        end
        edge_and_check();
    endtask

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        in1  = 1'b0;
        in8  = 8'h00;
        last1 = 1'b0;
        last8 = 8'h00;

        //          rst   load  in1   in8     exp1  exp8
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h3C};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h3C};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h3C};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 8'h81};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h7E, 1'b0, 8'h7E};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Glitch immunity: in pulses high between edges but settles low before the edge.
        step('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00}, "pre_glitch");
        @(negedge clk);
        load = 1'b1;
        in1  = 1'b0;
        in8  = 8'h00;
        #5;
        in1 = 1'b1;
        in8 = 8'hFF;
        #5;
        check("glitch_mid1", {7'b0, out1}, 8'h00);
        check("glitch_mid8", out8, 8'h00);
        #5;
        in1 = 1'b0;
        in8 = 8'h00;
        push_exp(1'b0, 8'h00, "glitch_after");
        edge_and_check();

        // Reset raised mid-cycle: loaded data stays visible until the edge.
        step('{1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 8'hC3}, "pre_rst");
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        #5;
        check("rst_pending1", {7'b0, out1}, 8'h01);
        check("rst_pending8", out8, 8'hC3);
        push_exp(1'b0, 8'hA5, "rst_taken");
        edge_and_check();

        // Release reset: the next edge loads again.
        step('{1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 8'h12}, "post_rst");

        check("scoreboard_drained", 8'(sb_q.size()), 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
